// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency 256-bit line memory answering data-cache fill and write-back requests
module data_memory_responder #(
    parameter int LATENCY     = 10,
    parameter int LINE_ADDR_W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         mem_enable_i,
    input  logic         mem_write_i,
    input  logic [31:0]  mem_addr_i,
    input  logic [255:0] mem_data_i,
    output logic         mem_ack_o,
    output logic [255:0] mem_data_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [7:0] LOAD   = 8'(LATENCY - 1);

    logic [255:0]           mem_q [0:(1 << LINE_ADDR_W) - 1];
    logic [1:0]             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [LINE_ADDR_W-1:0] idx_q;
    logic                   write_q;
    logic [255:0]           wdata_q;
    logic [255:0]           rdata_q;
    logic                   ack_q;
    logic                   accept;
    logic                   commit;
    logic                   unused_addr;

    assign unused_addr = ^{mem_addr_i[31:LINE_ADDR_W+5], mem_addr_i[4:0]};
    assign mem_ack_o   = ack_q;
    assign mem_data_o  = rdata_q;

    // Sequence one request: accept in IDLE, count down in WAIT, complete on the edge that enters ACK
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                accept  = mem_enable_i;
                state_d = mem_enable_i ? S_WAIT : S_IDLE;
                cnt_d   = mem_enable_i ? LOAD : cnt_q;
            end
            S_WAIT: begin
                commit  = (cnt_q == 8'd0);
                state_d = commit ? S_ACK : S_WAIT;
                cnt_d   = commit ? cnt_q : cnt_q - 8'd1;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control, latched request and read-data registers; a reset aborts any in-flight request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= commit;
            if (accept) begin
                idx_q   <= mem_addr_i[LINE_ADDR_W+4:5];
                write_q <= (mem_write_i === 1'b1);
                wdata_q <= mem_data_i;
            end
            if (commit && !write_q) rdata_q <= mem_q[idx_q];
        end
    end

    // Line storage keeps its contents across reset; writes land on the ack-entry edge only
    always_ff @(posedge clk_i) begin
        if (commit && write_q && !rst_i) mem_q[idx_q] <= wdata_q;
    end

`ifndef SYNTHESIS
    // An unknown write flag on an accepted request is reported and the request proceeds as a read
    always @(posedge clk_i) begin
        if (!rst_i && accept)
            assert (!$isunknown(mem_write_i))
            else $error("data_memory_responder: unknown mem_write_i at request acceptance");
    end
`endif
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed checks of latency, data, aliasing, held enable and reset abort
module tb_data_memory_responder;
    localparam logic [255:0] BEEF = {8{32'hDEADBEEF}};
    localparam logic [255:0] ONES = {256{1'b1}};
    localparam logic [255:0] P1   = {8{32'h1234_5678}};
    localparam logic [255:0] P2   = {8{32'hA5A5_0F0F}};
    localparam logic [255:0] P3   = {8{32'h0BAD_F00D}};

    logic         clk = 1'b0;
    logic         rst;
    logic         en   [2];
    logic         we   [2];
    logic         ack  [2];
    logic [31:0]  addr [2];
    logic [255:0] wd   [2];
    logic [255:0] rd   [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.LATENCY(10), .LINE_ADDR_W(9)) u0 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en[0]), .mem_write_i(we[0]),
        .mem_addr_i(addr[0]), .mem_data_i(wd[0]), .mem_ack_o(ack[0]), .mem_data_o(rd[0])
    );

    data_memory_responder #(.LATENCY(1), .LINE_ADDR_W(9)) u1 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en[1]), .mem_write_i(we[1]),
        .mem_addr_i(addr[1]), .mem_data_i(wd[1]), .mem_ack_o(ack[1]), .mem_data_o(rd[1])
    );

    task automatic do_req(input int u, input logic w, input logic [31:0] a, input logic [255:0] d,
                          input bit scr, output int lat, output logic ack_after);
        @(negedge clk);
        en[u] = 1'b1; we[u] = w; addr[u] = a; wd[u] = d;
        @(posedge clk); #1;
        lat = 0;
        while (ack[u] !== 1'b1 && lat < 300) begin
            if (scr) begin
                addr[u] = $urandom;
                wd[u]   = {8{$urandom}};
            end
            @(posedge clk); #1;
            lat++;
        end
        en[u] = 1'b0;
        @(posedge clk); #1;
        ack_after = ack[u];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            en[u] = 1'b0; we[u] = 1'b0; addr[u] = '0; wd[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (ack[u] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b expected 0", u, ack[u]); end
            checks++;
            if (rd[u] !== '0) begin errors++; $display("FAIL reset_data[%0d]: got %h expected 0", u, rd[u]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat;
        logic aa;
        do_req(0, 1'b1, 32'h40, BEEF, 1'b0, lat, aa);
        checks++;
        if (lat != 10) begin errors++; $display("FAIL write_latency: got %0d expected 10", lat); end
        checks++;
        if (aa !== 1'b0) begin errors++; $display("FAIL write_ack_width: got %b expected 0", aa); end
        checks++;
        if (rd[0] !== '0) begin errors++; $display("FAIL write_keeps_data_o: got %h expected 0", rd[0]); end
        do_req(0, 1'b0, 32'h40, '0, 1'b0, lat, aa);
        checks++;
        if (lat != 10) begin errors++; $display("FAIL read_latency: got %0d expected 10", lat); end
        checks++;
        if (rd[0] !== BEEF) begin errors++; $display("FAIL read_data: got %h expected %h", rd[0], BEEF); end
        checks++;
        if (aa !== 1'b0) begin errors++; $display("FAIL read_ack_width: got %b expected 0", aa); end
    endtask

    task automatic test_wait_changes();
        int lat;
        logic aa;
        do_req(0, 1'b1, 32'h60, P1, 1'b1, lat, aa);
        checks++;
        if (lat != 10) begin errors++; $display("FAIL scramble_write_latency: got %0d expected 10", lat); end
        do_req(0, 1'b0, 32'h60, '0, 1'b1, lat, aa);
        checks++;
        if (rd[0] !== P1) begin errors++; $display("FAIL scramble_read_data: got %h expected %h", rd[0], P1); end
        do_req(0, 1'b0, 32'h40, '0, 1'b0, lat, aa);
        checks++;
        if (rd[0] !== BEEF) begin errors++; $display("FAIL scramble_neighbour: got %h expected %h", rd[0], BEEF); end
    endtask

    task automatic test_alias();
        int lat;
        logic aa;
        do_req(0, 1'b0, 32'h60, '0, 1'b0, lat, aa);
        do_req(0, 1'b0, 32'h45, '0, 1'b0, lat, aa);
        checks++;
        if (rd[0] !== BEEF) begin errors++; $display("FAIL offset_ignored: got %h expected %h", rd[0], BEEF); end
        do_req(0, 1'b1, 32'h4040, P2, 1'b0, lat, aa);
        do_req(0, 1'b0, 32'h40, '0, 1'b0, lat, aa);
        checks++;
        if (rd[0] !== P2) begin errors++; $display("FAIL alias_wrap: got %h expected %h", rd[0], P2); end
    endtask

    task automatic test_hold(input int u, input int l);
        int first = -1;
        int second = -1;
        int n = 0;
        @(negedge clk);
        en[u] = 1'b1; we[u] = 1'b0; addr[u] = 32'h40;
        @(posedge clk); #1;
        for (int c = 1; c <= 2 * l + 8; c++) begin
            @(posedge clk); #1;
            if (ack[u] === 1'b1) begin
                n++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (c == l + 2) en[u] = 1'b0;
        end
        checks++;
        if (n != 2) begin errors++; $display("FAIL hold_ack_count[%0d]: got %0d expected 2", u, n); end
        checks++;
        if (first != l) begin errors++; $display("FAIL hold_first_ack[%0d]: got %0d expected %0d", u, first, l); end
        checks++;
        if (second != 2 * l + 2) begin errors++; $display("FAIL hold_second_ack[%0d]: got %0d expected %0d", u, second, 2 * l + 2); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int n = 0;
        logic aa;
        do_req(0, 1'b1, 32'h80, ONES, 1'b0, lat, aa);
        @(negedge clk);
        en[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h80; wd[0] = '0;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        en[0] = 1'b0;
        checks++;
        if (ack[0] !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b expected 0", ack[0]); end
        checks++;
        if (rd[0] !== '0) begin errors++; $display("FAIL abort_data: got %h expected 0", rd[0]); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ack[0] === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks expected 0", n); end
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 1'b0, 32'h80, '0, 1'b0, lat, aa);
        checks++;
        if (lat != 10) begin errors++; $display("FAIL abort_read_latency: got %0d expected 10", lat); end
        checks++;
        if (rd[0] !== ONES) begin errors++; $display("FAIL abort_write_dropped: got %h expected %h", rd[0], ONES); end
    endtask

    task automatic test_latency1();
        int lat;
        logic aa;
        do_req(1, 1'b1, 32'h100, P3, 1'b0, lat, aa);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL lat1_write_latency: got %0d expected 1", lat); end
        checks++;
        if (aa !== 1'b0) begin errors++; $display("FAIL lat1_ack_width: got %b expected 0", aa); end
        do_req(1, 1'b0, 32'h100, '0, 1'b0, lat, aa);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL lat1_read_latency: got %0d expected 1", lat); end
        checks++;
        if (rd[1] !== P3) begin errors++; $display("FAIL lat1_read_data: got %h expected %h", rd[1], P3); end
        test_hold(1, 1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_changes();
        test_alias();
        test_hold(0, 10);
        test_reset_abort();
        test_latency1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
